add_chain_8bit: RTL

Sequential multi-byte adder that adds two NUM_BYTES-wide operands one byte per cycle, least-significant byte first, propagating carry in a register between bytes. It is the addition counterpart of the 8-bit subtract-with-borrow unit and serves the FFT datapath wherever a wide sum must be built from 8-bit slices. A start/valid handshake frames each operation. The block reports per-byte sums and a final carry-out.

---
 rtl/add_chain_8bit.sv | 106 ++++++++++
 1 files changed

// File: rtl/add_chain_8bit.sv
// Sequential multi-byte adder: sums two NUM_BYTES-wide operands one byte per
// cycle, LSB first, with the carry held in a register between byte slices.
module add_chain_8bit #(
    parameter int NUM_BYTES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_carry,
    input  logic       i_valid,
    input  logic [7:0] i_data_a,
    input  logic [7:0] i_data_b,
    output logic [7:0] o_sum,
    output logic       o_sum_valid,
    output logic       o_carry,
    output logic       o_done,
    output logic       o_busy
);

    localparam int CNT_W = $clog2(NUM_BYTES) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       sum_q, sum_d;
    logic             sum_valid_q, sum_valid_d;
    logic             carry_out_q, carry_out_d;
    logic             done_q, done_d;
    logic [8:0]       add_res;

    assign add_res = {1'b0, i_data_a} + {1'b0, i_data_b} + {8'b0, carry_q};

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        carry_out_d = carry_out_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d     = RUN;
                    carry_d     = i_carry;
                    cnt_d       = '0;
                    carry_out_d = 1'b0;
                end
            end
            RUN: begin
                // Idle cycles (i_valid low) leave the chain untouched.
                if (i_valid) begin
                    sum_d       = add_res[7:0];
                    sum_valid_d = 1'b1;
                    carry_d     = add_res[8];
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        carry_out_d = add_res[8];
                        done_d      = 1'b1;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the combinational block above uses blocking ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= 8'h00;
            sum_valid_q <= 1'b0;
            carry_out_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            carry_out_q <= carry_out_d;
            done_q      <= done_d;
        end
    end

    assign o_sum       = sum_q;
    assign o_sum_valid = sum_valid_q;
    assign o_carry     = carry_out_q;
    assign o_done      = done_q;
    assign o_busy      = (state_q == RUN);

endmodule
